// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch datapath.
package mips_pkg;

  // Fetch-stage control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2
  } state_t;

  localparam int          INSTR_W = 32;
  localparam logic [31:0] PC_INC  = 32'd4;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC target mux: jump beats branch, branch beats sequential.
// Branch targets are word-aligned by clearing bits [1:0]. misalign flags a
// raw branch sum that was not word-aligned.
module pc_next_sel
  import mips_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic        jump_en,
  input  logic [27:0] jump_addr28,
  input  logic        branch_en,
  input  logic [31:0] branch_off,
  output logic [31:0] next_pc,
  output logic        misalign
);

  logic [31:0] branch_sum;

  assign branch_sum = pc_plus4 + branch_off;

  // Pick the redirect target. The alignment check applies only when the branch is chosen.
  always_comb begin
    next_pc  = pc_plus4;
    misalign = 1'b0;
    if (jump_en) begin
      next_pc = {pc_plus4[31:28], jump_addr28};
    end else if (branch_en) begin
      next_pc  = {branch_sum[31:2], 2'b00};
      misalign = |branch_sum[1:0];
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns the PC and issues req/ack fetches to instruction memory.
// Each fetched word is held until decode retires it. The redirect inputs are
// looked at only in the retire cycle.
module pc_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_W     = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] instr_in,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr_out,
  output logic [31:0]        pc_out,
  output logic [31:0]        pc_plus4,
  input  logic               stall,
  input  logic               jump_en,
  input  logic [27:0]        jump_addr28,
  input  logic               branch_en,
  input  logic [31:0]        branch_off,
  output logic               align_err
);

  state_t             state_reg;
  state_t             state_next;
  logic [PC_W-1:0]    pc_reg;
  logic [INSTR_W-1:0] instr_reg;
  logic               align_err_reg;
  logic [31:0]        next_pc;
  logic               misalign;
  logic               retire;

  // A held instruction leaves the stage when decode is not stalling.
  assign retire = (state_reg == VALID) && !stall;

  assign pc_plus4    = pc_reg + PC_INC;
  assign pc_out      = pc_reg;
  assign imem_addr   = pc_reg;
  assign imem_req    = (state_reg == FETCH);
  assign instr_valid = (state_reg == VALID);
  assign instr_out   = instr_reg;
  assign align_err   = align_err_reg;

  pc_next_sel u_next_sel (
    .pc_plus4    (pc_plus4),
    .jump_en     (jump_en),
    .jump_addr28 (jump_addr28),
    .branch_en   (branch_en),
    .branch_off  (branch_off),
    .next_pc     (next_pc),
    .misalign    (misalign)
  );

  // State transitions. imem_ack is honoured only while a request is outstanding.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    state_next = FETCH;
      FETCH:   if (imem_ack) state_next = VALID;
      VALID:   if (!stall) state_next = FETCH;
      default: state_next = IDLE;
    endcase
  end

  // State, PC, instruction capture and the sticky misalignment flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      pc_reg        <= RESET_PC;
      instr_reg     <= '0;
      align_err_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if ((state_reg == FETCH) && imem_ack) begin
        instr_reg <= instr_in;
      end
      if (retire) begin
        pc_reg <= next_pc;
        if (misalign) begin
          align_err_reg <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed plus randomized bench for pc_fetch_unit, checked against a
// PC/instruction reference model kept here.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] instr_in = 32'h0;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        stall = 1'b1;
  logic        jump_en = 1'b0;
  logic [27:0] jump_addr28 = 28'h0;
  logic        branch_en = 1'b0;
  logic [31:0] branch_off = 32'h0;
  logic        align_err;

  int checks = 0;
  int failures = 0;

  // Reference model state.
  logic [31:0] pc_m = 32'h0;
  logic [31:0] instr_m = 32'h0;
  logic        align_m = 1'b0;

  pc_fetch_unit #(.RESET_PC(32'h0000_0000), .PC_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .instr_in    (instr_in),
    .instr_valid (instr_valid),
    .instr_out   (instr_out),
    .pc_out      (pc_out),
    .pc_plus4    (pc_plus4),
    .stall       (stall),
    .jump_en     (jump_en),
    .jump_addr28 (jump_addr28),
    .branch_en   (branch_en),
    .branch_off  (branch_off),
    .align_err   (align_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a request, hold it for 'waits' cycles, then ack with a random word.
  task automatic do_fetch(input int waits);
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_bit("req_seen", imem_req, 1'b1);
    check("imem_addr", imem_addr, pc_m);
    check_bit("valid_low_in_fetch", instr_valid, 1'b0);
    for (int w = 0; w < waits; w++) begin
      @(negedge clk);
      check_bit("req_hold", imem_req, 1'b1);
      check("addr_hold", imem_addr, pc_m);
    end
    instr_m  = $urandom;
    instr_in = instr_m;
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    instr_in = $urandom;
    check_bit("valid_after_ack", instr_valid, 1'b1);
    check_bit("req_low_in_valid", imem_req, 1'b0);
    check("instr_out", instr_out, instr_m);
    check("pc_out", pc_out, pc_m);
    check("pc_plus4", pc_plus4, pc_m + 32'd4);
    check_bit("align_err", align_err, align_m);
  endtask

  // Retire the held instruction with the given redirect; expect the new fetch next cycle.
  task automatic do_retire(input logic j, input logic [27:0] ja, input logic b, input logic [31:0] bo);
    logic [31:0] p4;
    logic [31:0] sum;
    logic [31:0] old_pc;
    old_pc = pc_m;
    p4  = pc_m + 32'd4;
    sum = p4 + bo;
    if (j) begin
      pc_m = {p4[31:28], ja};
    end else if (b) begin
      pc_m = sum & 32'hFFFF_FFFC;
      if (sum[1:0] != 2'b00) align_m = 1'b1;
    end else begin
      pc_m = p4;
    end
    stall       = 1'b0;
    jump_en     = j;
    jump_addr28 = ja;
    branch_en   = b;
    branch_off  = bo;
    @(negedge clk);
    stall       = 1'b1;
    jump_en     = 1'($urandom_range(0, 1));
    jump_addr28 = 28'($urandom);
    branch_en   = 1'($urandom_range(0, 1));
    branch_off  = $urandom;
    check_bit("req_after_retire", imem_req, 1'b1);
    check("next_addr", imem_addr, pc_m);
    check_bit("valid_low_after_retire", instr_valid, 1'b0);
    check_bit("align_after_retire", align_err, align_m);
    $display("retire pc=%h j=%b b=%b off=%h -> next=%h align=%b", old_pc, j, b, bo, pc_m, align_m);
  endtask

  // Hold in VALID for k cycles with random redirect inputs and stray acks.
  task automatic do_stall(input int k);
    for (int i = 0; i < k; i++) begin
      stall       = 1'b1;
      jump_en     = 1'($urandom_range(0, 1));
      jump_addr28 = 28'($urandom);
      branch_en   = 1'($urandom_range(0, 1));
      branch_off  = $urandom;
      imem_ack    = 1'($urandom_range(0, 1));
      instr_in    = $urandom;
      @(negedge clk);
      check_bit("stall_valid", instr_valid, 1'b1);
      check_bit("stall_no_req", imem_req, 1'b0);
      check("stall_instr", instr_out, instr_m);
      check("stall_pc", pc_out, pc_m);
      check_bit("stall_align", align_err, align_m);
    end
    imem_ack = 1'b0;
  endtask

  initial begin
    // Reset values.
    repeat (2) @(negedge clk);
    check_bit("rst_req", imem_req, 1'b0);
    check_bit("rst_valid", instr_valid, 1'b0);
    check("rst_pc", pc_out, 32'h0);
    check("rst_instr", instr_out, 32'h0);
    check_bit("rst_align", align_err, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check_bit("req_after_idle", imem_req, 1'b1);

    // Sequential fetch 0, 4, 8 with one wait cycle.
    do_fetch(1); do_retire(1'b0, 28'h0, 1'b0, 32'h0);
    do_fetch(1); do_retire(1'b0, 28'h0, 1'b0, 32'h0);
    do_fetch(1); check("seq_addr8", pc_out, 32'h8);
    do_retire(1'b0, 28'h0, 1'b1, 32'hFFFF_FFF8);

    // Jump from 0x4, then into and across a region boundary.
    do_fetch(0); do_retire(1'b1, 28'h000_0010, 1'b0, 32'h0);
    check("jump_0x10", imem_addr, 32'h0000_0010);
    do_fetch(0); do_retire(1'b1, 28'hFFF_FFFC, 1'b0, 32'h0);
    do_fetch(0); do_retire(1'b1, 28'h000_0048, 1'b0, 32'h0);
    check("jump_region", imem_addr, 32'h1000_0048);

    // Branch to top of memory, then sequential wrap to 0.
    do_fetch(0); do_retire(1'b0, 28'h0, 1'b1, 32'hEFFF_FFB0);
    do_fetch(0); do_retire(1'b0, 28'h0, 1'b0, 32'h0);
    check("wrap_zero", imem_addr, 32'h0000_0000);

    // Backward branch from 0x100, then jump overriding a misaligned branch.
    do_fetch(0); do_retire(1'b0, 28'h0, 1'b1, 32'h0000_00FC);
    do_fetch(0); do_retire(1'b0, 28'h0, 1'b1, 32'hFFFF_FFF0);
    check("branch_back", imem_addr, 32'h0000_00F4);
    do_fetch(0); do_retire(1'b0, 28'h0, 1'b1, 32'h0000_0008);
    do_fetch(0); do_retire(1'b1, 28'h000_0020, 1'b1, 32'hFFFF_FFF2);
    check("jump_priority", imem_addr, 32'h0000_0020);
    check_bit("priority_no_align", align_err, 1'b0);

    // Stall hold, then a single redirect at release.
    do_fetch(2); do_stall(5);
    do_retire(1'b0, 28'h0, 1'b1, 32'h0000_01DC);

    // Misaligned branch sets the sticky flag.
    do_fetch(0); do_retire(1'b0, 28'h0, 1'b1, 32'h0000_0002);
    check("misalign_target", imem_addr, 32'h0000_0204);
    check_bit("align_set", align_err, 1'b1);
    do_fetch(1); do_retire(1'b0, 28'h0, 1'b0, 32'h0);
    check_bit("align_sticky", align_err, 1'b1);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      do_fetch($urandom_range(0, 3));
      do_stall($urandom_range(0, 3));
      do_retire(1'($urandom_range(0, 1)), 28'($urandom), 1'($urandom_range(0, 1)), $urandom);
    end

    // Reset while a fetch is outstanding; a late ack in IDLE must be ignored.
    @(negedge clk);
    check_bit("pre_rst_req", imem_req, 1'b1);
    rst_n = 1'b0;
    #1;
    check_bit("midrst_req", imem_req, 1'b0);
    check_bit("midrst_valid", instr_valid, 1'b0);
    check("midrst_pc", pc_out, 32'h0);
    check_bit("midrst_align", align_err, 1'b0);
    @(negedge clk);
    rst_n    = 1'b1;
    imem_ack = 1'b1;
    instr_in = $urandom;
    #1;
    check_bit("idle_req", imem_req, 1'b0);
    @(negedge clk);
    imem_ack = 1'b0;
    pc_m     = 32'h0;
    align_m  = 1'b0;
    check_bit("late_ack_ignored", instr_valid, 1'b0);
    check_bit("restart_req", imem_req, 1'b1);
    check("restart_addr", imem_addr, 32'h0);
    check("restart_instr", instr_out, 32'h0);
    do_fetch(1); do_retire(1'b0, 28'h0, 1'b0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
